qr_vote_combine: RTL

QR_VOTE_COMBINE -- requirements
Module: qr_vote_combine

---
 rtl/qr_vote_combine.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/qr_vote_combine.sv
// Combines several candidate QR grids into one: quadrant stitching across three
// frames, or per-bit majority voting across NUM_FRAMES frames.
module qr_vote_combine #(
    parameter int CODE_SIZE  = 21,
    parameter int NUM_FRAMES = 3,
    parameter int SPLIT      = 10
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           mode_in,
    input  logic                           abort_in,
    input  logic [CODE_SIZE*CODE_SIZE-1:0] grid_in,
    input  logic                           grid_valid_in,
    output logic                           grid_ready_out,
    output logic [CODE_SIZE*CODE_SIZE-1:0] qr_code_out,
    output logic                           qr_valid_out,
    output logic                           busy_out
);
    localparam int N  = CODE_SIZE * CODE_SIZE;
    localparam int CW = $clog2(NUM_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    // Region supplied by quadrant frame k (arrival order) of the combine.
    function automatic logic [N-1:0] region_mask(input int k);
        logic [N-1:0] m;
        m = '0;
        for (int y = 0; y < CODE_SIZE; y++) begin
            for (int x = 0; x < CODE_SIZE; x++) begin
                case (k)
                    0:       m[x + y*CODE_SIZE] = (x < SPLIT) && (y < SPLIT);
                    1:       m[x + y*CODE_SIZE] = (x >= SPLIT) && (y < SPLIT);
                    2:       m[x + y*CODE_SIZE] = (y >= SPLIT);
                    default: m[x + y*CODE_SIZE] = 1'b0;
                endcase
            end
        end
        return m;
    endfunction

    localparam logic [N-1:0] MASK0 = region_mask(0);
    localparam logic [N-1:0] MASK1 = region_mask(1);
    localparam logic [N-1:0] MASK2 = region_mask(2);

    state_t                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [3:0]             idx_q, idx_d;
    logic [N-1:0]           acc_q, acc_d;
    logic [N-1:0]           code_q, code_d;
    logic [N-1:0][CW-1:0]   cnt_q, cnt_d;

    logic                   accept;
    logic                   mode_eff;
    logic                   last;
    logic [3:0]             target;
    logic [N-1:0]           frame_mask;
    logic [N-1:0]           maj;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        grid_ready_out = (state_q != EMIT);
        accept         = grid_valid_in && grid_ready_out && !abort_in;
        mode_eff       = (state_q == IDLE) ? mode_in : mode_q;
        target         = mode_eff ? 4'(NUM_FRAMES) : 4'd3;
        last           = accept && ((idx_q + 4'd1) == target);

        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE, COLLECT: begin
                if (abort_in) begin
                    state_d = IDLE;
                end else if (accept) begin
                    mode_d  = mode_eff;
                    state_d = last ? EMIT : COLLECT;
                end
            end
            EMIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (idx_q)
            4'd0:    frame_mask = MASK0;
            4'd1:    frame_mask = MASK1;
            4'd2:    frame_mask = MASK2;
            default: frame_mask = '0;
        endcase

        idx_d  = idx_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        code_d = code_q;
        if (accept) begin
            idx_d = idx_q + 4'd1;
            acc_d = acc_q | (grid_in & frame_mask);
            for (int i = 0; i < N; i++) begin
                cnt_d[i] = cnt_q[i] + CW'(grid_in[i]);
            end
        end

        for (int i = 0; i < N; i++) begin
            maj[i] = {cnt_d[i], 1'b0} > (CW+1)'(NUM_FRAMES);
        end
        if (last) begin
            code_d = mode_eff ? maj : acc_d;
        end

        // Every path back to IDLE (abort, end of emit) starts the next combine from zero.
        if (state_d == IDLE) begin
            idx_d = '0;
            acc_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst_in) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            code_q  <= '0;
            // NOTE: the vote counters are real state that must start from zero, so they are reset
            // rather than left as an uninitialised memory.
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    assign qr_code_out  = code_q;
    assign qr_valid_out = (state_q == EMIT);
    assign busy_out     = (state_q == COLLECT);

endmodule
